// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the iterative shift sequencer.
//   WIDTH    - default datapath width
//   op_e     - operation encoding (matches the 2-bit Op request field)
//   state_e  - sequencer state encoding
package shift_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-bit shift/rotate of a data word.
//   data_i - word to shift
//   op_i   - operation (op_e encoding)
//   sign_i - fill bit for arithmetic right shift (latched operand sign)
//   data_o - word shifted by exactly one position
module shift_step #(
  parameter int WIDTH = shift_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);
  import shift_pkg::*;

  always_comb begin
    data_o = data_i;
    case (op_e'(op_i))
      OP_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_SRA:  data_o = {sign_i, data_i[WIDTH-1:1]};
      OP_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter, one bit position per clock.
//   Clock, ResetN           - rising-edge clock, async active-low reset
//   StartValid/StartReady   - request handshake (Op, A, SHAMT sampled)
//   Op                      - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   A, SHAMT                - operand and full-width shift amount
//   ResultValid/ResultReady - result handshake, Result held while valid
//   Busy                    - sequencer is not idle
module shift_sequencer #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             StartValid,
  output logic             StartReady,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] SHAMT,
  output logic             ResultValid,
  input  logic             ResultReady,
  output logic [WIDTH-1:0] Result,
  output logic             Busy
);
  import shift_pkg::*;

  localparam int               RW      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic               start_ready_q, result_valid_q, busy_q;
  logic [CNT_W-1:0]   cnt_eff;
  logic [WIDTH-1:0]   step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .sign_i (sign_q),
    .data_o (step_out)
  );

  // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH, which
  // naturally drains the word to all-zero / all-sign.
  always_comb begin
    if (op_e'(Op) == OP_ROR)  cnt_eff = CNT_W'(SHAMT[RW-1:0]);
    else if (SHAMT >= WIDTH_V) cnt_eff = CNT_W'(WIDTH);
    else                       cnt_eff = CNT_W'(SHAMT);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        // start_ready_q (not the state) gates acceptance so nothing is
        // taken before the first edge after reset release.
        if (StartValid && start_ready_q) begin
          op_d    = Op;
          data_d  = A;
          sign_d  = A[WIDTH-1];
          cnt_d   = cnt_eff;
          state_d = (cnt_eff == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ResultReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state, so they
  // track the state exactly but read 0 while reset is asserted.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q        <= ST_IDLE;
      data_q         <= '0;
      cnt_q          <= '0;
      op_q           <= 2'b00;
      sign_q         <= 1'b0;
      start_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      sign_q         <= sign_d;
      start_ready_q  <= (state_d == ST_IDLE);
      result_valid_q <= (state_d == ST_DONE);
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign StartReady  = start_ready_q;
  assign ResultValid = result_valid_q;
  assign Busy        = busy_q;
  assign Result      = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table vectors, hand-written corner sequences and
// randomized transactions checked against an arithmetic reference model.
module tb_shift_sequencer;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        StartValid;
  logic        StartReady;
  logic [1:0]  Op;
  logic [15:0] A;
  logic [15:0] SHAMT;
  logic        ResultValid;
  logic        ResultReady;
  logic [15:0] Result;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .StartValid  (StartValid),
    .StartReady  (StartReady),
    .Op          (Op),
    .A           (A),
    .SHAMT       (SHAMT),
    .ResultValid (ResultValid),
    .ResultReady (ResultReady),
    .Result      (Result),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] shamt;
    logic [15:0] res;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no bit-serial stepping.
  function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] s);
    logic [31:0] w;
    case (op)
      2'd0: return (s >= 16) ? 16'h0 : (a << s);
      2'd1: return (s >= 16) ? 16'h0 : (a >> s);
      2'd2: return (s >= 16) ? {16{a[15]}} : 16'($signed(a) >>> s);
      default: begin
        w = {a, a} >> (s % 16);
        return w[15:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [15:0] s);
    if (op == 2'd3) return int'(s % 16) + 1;
    return ((s >= 16) ? 16 : int'(s)) + 1;
  endfunction

  // One full transaction; hold = cycles ResultReady stays low in DONE.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] s, input logic [15:0] exp_res,
                         input int exp_lat, input int hold);
    int n;
    int edges;
    n = 0;
    while (!StartReady && n < 50) begin tick(); n++; end
    if (!StartReady) chk({tag, " start_ready_timeout"}, 32'(StartReady), 32'd1);
    StartValid  = 1'b1;
    Op = op; A = a; SHAMT = s;
    ResultReady = (hold == 0);
    tick();
    // Scramble request inputs: the latched copies must be used.
    StartValid = 1'b0;
    Op = 2'($urandom); A = 16'($urandom); SHAMT = 16'($urandom);
    edges = 1;
    while (!ResultValid && edges < 40) begin tick(); edges++; end
    chk({tag, " latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, " result"}, 32'(Result), 32'(exp_res));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " held_valid"}, 32'(ResultValid), 32'd1);
    end
    ResultReady = 1'b1;
    tick();
    chk({tag, " after_hs"}, {30'd0, ResultValid, StartReady}, 32'b01);
    ResultReady = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    logic [1:0]  rop;
    logic [15:0] ra, rs;

    vecs.push_back('{2'd2, 16'h8001, 16'd3,      16'hF000, 4});
    vecs.push_back('{2'd1, 16'h8001, 16'd20,     16'h0000, 17});
    vecs.push_back('{2'd2, 16'h8001, 16'd20,     16'hFFFF, 17});
    vecs.push_back('{2'd0, 16'h1234, 16'd0,      16'h1234, 1});
    vecs.push_back('{2'd3, 16'h0001, 16'h0011,   16'h8000, 2});
    vecs.push_back('{2'd0, 16'h1234, 16'd4,      16'h2340, 5});
    vecs.push_back('{2'd3, 16'h1234, 16'd4,      16'h4123, 5});
    vecs.push_back('{2'd1, 16'hF0F0, 16'd16,     16'h0000, 17});
    vecs.push_back('{2'd0, 16'hFFFF, 16'd15,     16'h8000, 16});
    vecs.push_back('{2'd3, 16'hABCD, 16'h0010,   16'hABCD, 1});
    vecs.push_back('{2'd2, 16'h7FFF, 16'hFFFF,   16'h0000, 17});
    vecs.push_back('{2'd0, 16'h0001, 16'h1000,   16'h0000, 17});

    ResetN = 1'b0; StartValid = 1'b0; ResultReady = 1'b0;
    Op = 2'd0; A = 16'h0; SHAMT = 16'h0;

    // Reset state, including across a clock edge while held.
    #2;
    chk("rst outputs", {13'd0, StartReady, ResultValid, Busy, Result}, 32'h0);
    tick();
    StartValid = 1'b1;
    chk("rst held outputs", {13'd0, StartReady, ResultValid, Busy, Result}, 32'h0);
    ResetN = 1'b1;
    #1;
    chk("rst released ready", 32'(StartReady), 32'd0);
    StartValid = 1'b0;
    tick();
    chk("ready after release", {30'd0, StartReady, Busy}, 32'b10);

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].shamt,
              vecs[i].res, vecs[i].lat, 0);

    // Consumer stalls in DONE while a new request is offered.
    run_txn("stall_pre", 2'd1, 16'hFF00, 16'd4, 16'h0FF0, 5, 0);
    StartValid = 1'b1; Op = 2'd1; A = 16'hFF00; SHAMT = 16'd4;
    ResultReady = 1'b0;
    tick();
    StartValid = 1'b0;
    begin
      int e;
      e = 1;
      while (!ResultValid && e < 40) begin tick(); e++; end
      chk("stall latency", 32'(e), 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      StartValid = 1'b1; A = 16'($urandom); Op = 2'($urandom); SHAMT = 16'($urandom);
      tick();
      chk("stall held", {14'd0, ResultValid, StartReady, Result}, {14'd0, 2'b10, 16'h0FF0});
    end
    ResultReady = 1'b1;
    tick();
    chk("stall exit", {29'd0, ResultValid, StartReady, Busy}, 32'b010);
    StartValid = 1'b0; ResultReady = 1'b0;
    tick();
    chk("stall idle", 32'(Busy), 32'd0);

    // Reset in the middle of a long shift.
    StartValid = 1'b1; Op = 2'd0; A = 16'h00FF; SHAMT = 16'd10;
    tick();
    StartValid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid shift busy", {30'd0, Busy, ResultValid}, 32'b10);
    ResetN = 1'b0;
    #1;
    chk("mid reset outputs", {13'd0, StartReady, ResultValid, Busy, Result}, 32'h0);
    #1;
    ResetN = 1'b1;
    tick();
    chk("post reset ready", {30'd0, StartReady, ResultValid}, 32'b10);
    run_txn("post_reset", 2'd0, 16'h00FF, 16'd10, 16'hFC00, 11, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = 16'($urandom);
      rs  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      run_txn($sformatf("rnd%0d", i), rop, ra, rs, ref_res(rop, ra, rs),
              ref_lat(rop, rs), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
